// File: rtl/vga_sprite_module.sv
// VGA timing generator with a single colour-keyed, integer-scaled sprite.
// Sync, DE and RGB leave through a common ROM_LAT+2 clock pipeline.
module vga_sprite_module #(
  parameter int H_ACTIVE   = 800,
  parameter int H_FP       = 40,
  parameter int H_SYNC     = 128,
  parameter int H_BP       = 88,
  parameter int V_ACTIVE   = 600,
  parameter int V_FP       = 1,
  parameter int V_SYNC     = 4,
  parameter int V_BP       = 23,
  parameter bit SYNC_POL   = 1'b1,
  parameter int COLOR_W    = 4,
  parameter int SPR_W      = 64,
  parameter int SPR_H      = 64,
  parameter int ADDR_W     = 12,
  parameter int ROM_LAT    = 1,
  parameter int SCALE_LOG2 = 0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [10:0]          Sprite_X,
  input  logic [10:0]          Sprite_Y,
  input  logic                 Key_En,
  input  logic [3*COLOR_W-1:0] Key_Color,
  input  logic [3*COLOR_W-1:0] Bg_Color,
  output logic [ADDR_W-1:0]    Rom_Addr,
  input  logic [3*COLOR_W-1:0] Rom_Data,
  output logic                 HSYNC_Sig,
  output logic                 VSYNC_Sig,
  output logic                 DE_Sig,
  output logic [COLOR_W-1:0]   Red_Sig,
  output logic [COLOR_W-1:0]   Green_Sig,
  output logic [COLOR_W-1:0]   Blue_Sig,
  output logic                 Frame_Start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW      = $clog2(SPR_W);
  localparam int YW      = $clog2(SPR_H);

  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT   = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] SPAN_X  = 12'(SPR_W << SCALE_LOG2);
  localparam logic [11:0] SPAN_Y  = 12'(SPR_H << SCALE_LOG2);

  typedef struct packed {
    logic hit;
    logic de;
    logic hs;
    logic vs;
    logic fs;
  } flags_t;

  logic [10:0] h_cnt, v_cnt;
  logic [10:0] sx, sy;
  logic [11:0] dx, dy;
  flags_t      raw_fl;
  flags_t      pipe [ROM_LAT+1];
  flags_t      out_fl;
  logic [3*COLOR_W-1:0] rgb_q;
  logic        key_match;

  // Position is latched only at the start of vertical blanking so a frame never tears.
  always_ff @(posedge CLK) begin
    if (RST) begin
      h_cnt <= '0;
      v_cnt <= '0;
      sx    <= '0;
      sy    <= '0;
    end else begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 11'd1;
      end else begin
        h_cnt <= h_cnt + 11'd1;
      end
      if (h_cnt == '0 && v_cnt == V_ACT) begin
        sx <= Sprite_X;
        sy <= Sprite_Y;
      end
    end
  end

  always_comb begin
    dx        = {1'b0, h_cnt} - {1'b0, sx};
    dy        = {1'b0, v_cnt} - {1'b0, sy};
    raw_fl.de = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    raw_fl.hs = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    raw_fl.vs = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    raw_fl.fs = (h_cnt == '0) && (v_cnt == '0);
    // Negative offsets (bit 11) are misses; no wrap past the right or bottom edge.
    raw_fl.hit = raw_fl.de && !dx[11] && (dx < SPAN_X) && !dy[11] && (dy < SPAN_Y);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i <= ROM_LAT; i++) pipe[i] <= '0;
      Rom_Addr <= '0;
    end else begin
      pipe[0] <= raw_fl;
      for (int unsigned i = 1; i <= ROM_LAT; i++) pipe[i] <= pipe[i-1];
      if (raw_fl.hit)
        Rom_Addr <= {dy[YW+SCALE_LOG2-1:SCALE_LOG2], dx[XW+SCALE_LOG2-1:SCALE_LOG2]};
    end
  end

  always_comb begin
    out_fl    = pipe[ROM_LAT];
    key_match = Key_En && (Rom_Data == Key_Color);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      HSYNC_Sig   <= ~SYNC_POL;
      VSYNC_Sig   <= ~SYNC_POL;
      DE_Sig      <= 1'b0;
      Frame_Start <= 1'b0;
      rgb_q       <= '0;
    end else begin
      HSYNC_Sig   <= out_fl.hs ? SYNC_POL : ~SYNC_POL;
      VSYNC_Sig   <= out_fl.vs ? SYNC_POL : ~SYNC_POL;
      DE_Sig      <= out_fl.de;
      Frame_Start <= out_fl.fs;
      if (!out_fl.de)
        rgb_q <= '0;
      else if (out_fl.hit && !key_match)
        rgb_q <= Rom_Data;
      else
        rgb_q <= Bg_Color;
    end
  end

  assign Red_Sig   = rgb_q[3*COLOR_W-1:2*COLOR_W];
  assign Green_Sig = rgb_q[2*COLOR_W-1:COLOR_W];
  assign Blue_Sig  = rgb_q[COLOR_W-1:0];

endmodule
